// File: rtl/div_unit_if.sv
// ============================================================================
// Module      : div_unit_if
// Description : Operand/result bundle between the issue/EX stage and div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, a, b, cancel,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, is_signed, a, b, cancel,
        output busy, done, quotient, remainder
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
//               (LO <= quotient, HI <= remainder). Define DIV_ZERO_FAST_EN to
//               let a zero divisor bypass the iteration phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    assign w_accept = bus.start && !bus.cancel &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a) + WIDTH'(1) : bus.a;
    assign w_b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b) + WIDTH'(1) : bus.b;

    // One restoring step: bring in the next dividend bit, then try subtracting.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.cancel) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                        w_state_nxt = (bus.b == '0) ? S_FIX : S_CALC;
`else
                        w_state_nxt = S_CALC;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CALC:  w_state_nxt = w_last ? S_FIX : S_CALC;
                S_FIX:   w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_a_raw <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            if (w_accept) begin
                r_neg_q <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg_r <= bus.is_signed && bus.a[WIDTH-1];
                r_div0  <= (bus.b == '0);
                r_a_raw <= bus.a;
                r_dvd   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_CALC && !bus.cancel) begin
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Result registers change only here, so a flush leaves the last result intact.
            if (r_state == S_FIX && !bus.cancel) begin
                if (r_div0) begin
                    r_quot <= '1;
                    r_remo <= r_a_raw;
                end else begin
                    r_quot <= r_neg_q ? (~r_dvd) + WIDTH'(1) : r_dvd;
                    r_remo <= r_neg_r ? (~r_rem) + WIDTH'(1) : r_rem;
                end
            end
        end
    end

    assign bus.busy      = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done      = (r_state == S_DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit (DIV/DIVU results,
//               latency, cancel, back-to-back and reset behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;
    localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = 34;
`endif

    logic clk;
    logic resetn;
    int   tests;
    int   fails;
    int   lat;
    int   bcnt;
    int   seen_done;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one divide, scrambles the operands after accept and waits for done.
    // lat counts cycles after the accept edge; optionally pokes start mid-CALC.
    task automatic run_div(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                           input bit glitch, output int l, output int bc);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.a         = av;
        bus.b         = bv;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = ~sgn;
        l  = 1;
        bc = 0;
        while (bus.done !== 1'b1 && l < 200) begin
            if (bus.busy === 1'b1) bc++;
            bus.start = glitch && (l == 5);
            @(posedge clk);
            #1;
            l++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cancel    = 1'b0;
        resetn        = 1'b1;
        #2 resetn     = 1'b0;
        step(2);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_quot", bus.quotient, 32'd0);
        chk("rst_rem",  bus.remainder, 32'd0);
        resetn = 1'b1;
        step(1);

        // DIVU 100 / 7
        run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, bcnt);
        chk("divu_lat",  lat, 32'd34);
        chk("divu_busy", bcnt, 32'd33);
        chk("divu_q", bus.quotient, 32'd14);
        chk("divu_r", bus.remainder, 32'd2);
        step(1);
        chk("done_pulse", {31'b0, bus.done}, 32'd0);

        // Signed quadrants
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt);
        chk("div_neg_a_q", bus.quotient, 32'hFFFF_FFFD);
        chk("div_neg_a_r", bus.remainder, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, bcnt);
        chk("div_neg_b_q", bus.quotient, 32'hFFFF_FFFD);
        chk("div_neg_b_r", bus.remainder, 32'd1);

        // Overflow case, signed and unsigned
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
        chk("ovf_s_q", bus.quotient, 32'h8000_0000);
        chk("ovf_s_r", bus.remainder, 32'd0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
        chk("ovf_u_q", bus.quotient, 32'd0);
        chk("ovf_u_r", bus.remainder, 32'h8000_0000);

        // Divide by zero
        run_div(1'b0, 32'h1234_5678, 32'd0, 1'b0, lat, bcnt);
        chk("dz_u_lat", lat, DZ_LAT);
        chk("dz_u_q", bus.quotient, 32'hFFFF_FFFF);
        chk("dz_u_r", bus.remainder, 32'h1234_5678);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, lat, bcnt);
        chk("dz_s_lat", lat, DZ_LAT);
        chk("dz_s_q", bus.quotient, 32'hFFFF_FFFF);
        chk("dz_s_r", bus.remainder, 32'hFFFF_FFF9);

        // start during CALC is ignored
        run_div(1'b0, 32'd1000, 32'd10, 1'b1, lat, bcnt);
        chk("ign_lat", lat, 32'd34);
        chk("ign_q", bus.quotient, 32'd100);
        chk("ign_r", bus.remainder, 32'd0);
        step(2);

        // Cancel at cycle N+10
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.a = 32'd100;
        bus.b = 32'd7;
        step(1);
        bus.start = 1'b0;
        step(9);
        chk("cxl_busy_before", {31'b0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        step(1);
        bus.cancel = 1'b0;
        chk("cxl_busy_after", {31'b0, bus.busy}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen_done++;
            step(1);
        end
        chk("cxl_no_done", seen_done, 32'd0);
        chk("cxl_hold_q", bus.quotient, 32'd100);
        chk("cxl_hold_r", bus.remainder, 32'd0);

        // cancel together with start in IDLE drops the start
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd3;
        step(1);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("cxl_start_busy", {31'b0, bus.busy}, 32'd0);

        run_div(1'b0, 32'd9, 32'd3, 1'b0, lat, bcnt);
        chk("post_cxl_lat", lat, 32'd34);
        chk("post_cxl_q", bus.quotient, 32'd3);
        chk("post_cxl_r", bus.remainder, 32'd0);
        step(1);

        // Back-to-back: second start lands in the DONE cycle
        run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, bcnt);
        chk("b2b_first_q", bus.quotient, 32'd14);
        run_div(1'b0, 32'd50, 32'd5, 1'b0, lat, bcnt);
        chk("b2b_lat", lat, 32'd34);
        chk("b2b_q", bus.quotient, 32'd10);
        chk("b2b_r", bus.remainder, 32'd0);
        step(1);

        // Asynchronous reset mid-CALC
        bus.start = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd7;
        step(1);
        bus.start = 1'b0;
        step(5);
        resetn = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_q", bus.quotient, 32'd0);
        chk("arst_r", bus.remainder, 32'd0);
        step(1);
        resetn = 1'b1;
        step(1);
        run_div(1'b0, 32'd50, 32'd5, 1'b0, lat, bcnt);
        chk("post_rst_lat", lat, 32'd34);
        chk("post_rst_q", bus.quotient, 32'd10);
        chk("post_rst_r", bus.remainder, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
